// File: rtl/dwt_decim2_pack.sv
// dwt_decim2_pack: dyadic downsample-by-2 that repacks two decimated beats into one full word.
// Lane m of a bus is bits [m*DATA_WIDTH +: DATA_WIDTH]; lane 0 is the oldest sample.
module dwt_decim2_pack #(
    parameter int NUM_CHANNELS = 16,
    parameter int DATA_WIDTH   = 20,
    parameter int PHASE        = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               valid_in,
    input  logic                               sync_in,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_in,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] y_out,
    output logic                               valid_out,
    output logic                               partial_drop
);
    localparam int H = NUM_CHANNELS / 2;
    localparam int W = DATA_WIDTH;
    logic [H*W-1:0] kept, hold_q, hold_d;
    logic [NUM_CHANNELS*W-1:0] y_q, y_d;
    logic half_q, half_d, valid_q, valid_d, drop_q, drop_d, first, second;
    logic unused_lanes;
    genvar i;
    generate
        for (i = 0; i < H; i++) begin : g_sel
            assign kept[i*W +: W] = data_in[(2*i+PHASE)*W +: W];
        end
    endgenerate
    // The discarded parity of lanes is intentionally left unread.
    assign unused_lanes = ^data_in;
    always_comb begin
        first   = valid_in & (sync_in | ~half_q);
        second  = valid_in & ~sync_in & half_q;
        half_d  = valid_in ? first : half_q;
        hold_d  = first ? kept : hold_q;
        y_d     = second ? {kept, hold_q} : y_q;
        valid_d = second;
        drop_d  = valid_in & sync_in & half_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            half_q  <= 1'b0;
            hold_q  <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            half_q  <= half_d;
            hold_q  <= hold_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end
    assign y_out        = y_q;
    assign valid_out    = valid_q;
    assign partial_drop = drop_q;
endmodule

// File: tb/tb_dwt_decim2_pack.sv
// tb_dwt_decim2_pack: vector table, corner sequences and random traffic against a sample-queue model.
module tb_dwt_decim2_pack;
    localparam int N = 16;
    localparam int W = 20;
    localparam int NW = N * W;
    logic clk = 1'b0;
    logic rst, valid_in, sync_in;
    logic [NW-1:0] data_in;
    logic [NW-1:0] y0, y1;
    logic v0, v1, d0, d1;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    dwt_decim2_pack #(.NUM_CHANNELS(N), .DATA_WIDTH(W), .PHASE(0)) u0 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .sync_in(sync_in),
        .y_out(y0), .valid_out(v0), .partial_drop(d0));
    dwt_decim2_pack #(.NUM_CHANNELS(N), .DATA_WIDTH(W), .PHASE(1)) u1 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .sync_in(sync_in),
        .y_out(y1), .valid_out(v1), .partial_drop(d1));
    // Model: per phase, a buffer of retained samples in arrival order; a full buffer is a word.
    logic [W-1:0] mem [2][N];
    int cnt [2];
    logic [NW-1:0] my [2];
    bit mv [2], md [2];
    typedef struct {
        bit r, v, s;
        int base;
        bit ev, ed;
        int ya, yb;
    } vec_t;
    vec_t tbl[$];
    function automatic logic [NW-1:0] ramp(input int base);
        logic [NW-1:0] d;
        for (int m = 0; m < N; m++) d[m*W +: W] = W'(base + m);
        return d;
    endfunction
    function automatic int lane(input logic [NW-1:0] d, input int m);
        return int'(d[m*W +: W]);
    endfunction
    task automatic model(input bit r, input bit v, input bit s, input logic [NW-1:0] d);
        for (int p = 0; p < 2; p++) begin
            mv[p] = 0;
            md[p] = 0;
            if (r) begin
                cnt[p] = 0;
                my[p] = '0;
            end else if (v) begin
                if (s && cnt[p] > 0) begin
                    md[p] = 1;
                    cnt[p] = 0;
                end
                for (int m = 0; m < N; m++)
                    if (m % 2 == p) begin
                        mem[p][cnt[p]] = d[m*W +: W];
                        cnt[p]++;
                    end
                if (cnt[p] == N) begin
                    for (int k = 0; k < N; k++) my[p][k*W +: W] = mem[p][k];
                    mv[p] = 1;
                    cnt[p] = 0;
                end
            end
        end
    endtask
    task automatic chk(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic step(input bit r, input bit v, input bit s, input logic [NW-1:0] d);
        rst = r;
        valid_in = v;
        sync_in = s;
        data_in = d;
        @(posedge clk);
        #1;
        model(r, v, s, d);
        chk("p0_valid", NW'(v0), NW'(mv[0]));
        chk("p0_drop", NW'(d0), NW'(md[0]));
        chk("p0_y", y0, my[0]);
        chk("p1_valid", NW'(v1), NW'(mv[1]));
        chk("p1_drop", NW'(d1), NW'(md[1]));
        chk("p1_y", y1, my[1]);
        chk("p0_exclusive", NW'(v0 & d0), '0);
    endtask
    function automatic vec_t V(bit r, bit v, bit s, int base, bit ev, bit ed, int ya, int yb);
        vec_t t;
        t.r = r; t.v = v; t.s = s; t.base = base;
        t.ev = ev; t.ed = ed; t.ya = ya; t.yb = yb;
        return t;
    endfunction
    initial begin
        logic [NW-1:0] alt;
        logic [NW-1:0] exp_alt;
        cnt[0] = 0;
        cnt[1] = 0;
        rst = 1'b1; valid_in = 1'b0; sync_in = 1'b0; data_in = '0;
        // Expected PHASE=0 lane 0 / lane 15 values are hand-derived from the ramp pattern.
        tbl.push_back(V(1, 0, 0,   0, 0, 0,   0,   0));
        tbl.push_back(V(0, 1, 0,   0, 0, 0,   0,   0));
        tbl.push_back(V(0, 1, 0,  16, 1, 0,   0,  30));
        tbl.push_back(V(0, 1, 0,  32, 0, 0,   0,  30));
        tbl.push_back(V(0, 1, 0,  48, 1, 0,  32,  62));
        tbl.push_back(V(0, 1, 0,  64, 0, 0,  32,  62));
        tbl.push_back(V(0, 1, 0,  80, 1, 0,  64,  94));
        tbl.push_back(V(0, 0, 0,   0, 0, 0,  64,  94));
        tbl.push_back(V(0, 1, 0, 100, 0, 0,  64,  94));
        tbl.push_back(V(0, 1, 1, 200, 0, 1,  64,  94));
        tbl.push_back(V(0, 1, 0, 300, 1, 0, 200, 314));
        tbl.push_back(V(0, 1, 0, 100, 0, 0, 200, 314));
        tbl.push_back(V(1, 1, 0, 500, 0, 0,   0,   0));
        tbl.push_back(V(0, 1, 0, 200, 0, 0,   0,   0));
        tbl.push_back(V(0, 1, 0, 300, 1, 0, 200, 314));
        tbl.push_back(V(0, 1, 1,   0, 0, 0, 200, 314));
        tbl.push_back(V(0, 1, 0,  16, 1, 0,   0,  30));
        tbl.push_back(V(0, 1, 0, 400, 0, 0,   0,  30));
        tbl.push_back(V(0, 0, 1, 900, 0, 0,   0,  30));
        tbl.push_back(V(0, 1, 0, 416, 1, 0, 400, 430));
        foreach (tbl[k]) begin
            step(tbl[k].r, tbl[k].v, tbl[k].s, ramp(tbl[k].base));
            chk("tbl_valid", NW'(v0), NW'(tbl[k].ev));
            chk("tbl_drop", NW'(d0), NW'(tbl[k].ed));
            chk("tbl_lane0", NW'(lane(y0, 0)), NW'(tbl[k].ya));
            chk("tbl_lane15", NW'(lane(y0, 15)), NW'(tbl[k].yb));
        end
        step(1, 0, 0, '0);
        step(0, 1, 0, ramp(0));
        step(0, 1, 0, ramp(16));
        for (int k = 0; k < N; k++) chk("phase1_word", NW'(lane(y1, k)), NW'(2*k + 1));
        step(0, 1, 0, ramp(0));
        for (int g = 0; g < 7; g++) begin
            step(0, 0, 0, ramp(999));
            chk("gap_no_pulse", NW'(v0), '0);
        end
        step(0, 1, 0, ramp(16));
        chk("gap_pulse", NW'(v0), NW'(1));
        for (int k = 0; k < N; k++) chk("gap_word", NW'(lane(y0, k)), NW'(2*k));
        for (int m = 0; m < N; m++) alt[m*W +: W] = (m % 2 == 0) ? 20'h80000 : 20'h7FFFF;
        step(0, 1, 0, alt);
        step(0, 1, 0, alt);
        for (int m = 0; m < N; m++) exp_alt[m*W +: W] = 20'h80000;
        chk("sign_p0", y0, exp_alt);
        for (int m = 0; m < N; m++) exp_alt[m*W +: W] = 20'h7FFFF;
        chk("sign_p1", y1, exp_alt);
        for (int k = 0; k < 400; k++) begin
            logic [NW-1:0] d;
            for (int m = 0; m < N; m++) d[m*W +: W] = W'($urandom);
            step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, d);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
